// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory behind valid/ready request
// and response channels, with configurable wait states between accept and
// response. One transaction is in flight at a time.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_next;

  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          leave_resp;
  logic          acc_write;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_in_range;
  logic [AW-1:0] acc_index;

  // Ready and response-valid are pure state decodes, so an async reset
  // drops rsp_valid and raises req_ready immediately.
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  // With no wait states the access happens on the accept edge itself, so the
  // live request fields are used instead of the latched copy.
  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == S_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  // The range check uses the full 32-bit address; the index is only trusted
  // once that check passes.
  assign acc_in_range = (acc_addr < DEPTH);
  assign acc_index    = acc_addr[AW-1:0];

  // Next-state logic: IDLE accepts, WAIT counts down, RESP waits for consume.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    enter_resp    = 1'b0;
    leave_resp    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_next = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next    = S_WAIT;
            wait_cnt_next = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd1) begin
          state_next    = S_RESP;
          enter_resp    = 1'b1;
          wait_cnt_next = 4'd0;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
          leave_resp = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, wait counter, busy flag and latched request fields.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      busy      <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      busy     <= (state_next != S_IDLE);
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
    end
  end

  // Response data and error are captured entering RESP and cleared leaving it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= !acc_in_range;
      rsp_rdata <= (!acc_write && acc_in_range) ? mem[acc_index] : 32'd0;
    end else if (leave_resp) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end
  end

  // Array write commits on the edge entering RESP; the array itself is never
  // cleared, and nothing is written while reset is held.
  always_ff @(posedge clock) begin
    if (reset_n && enter_resp && acc_write && acc_in_range) begin
      mem[acc_index] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: three responders (0, 3 and 2 wait states) exercised
// with directed scenarios and random traffic against an array memory model.
module tb_data_mem_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        busy      [3];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model_mem     [3][1024];
  bit          model_written [3][1024];

  // Free-running 10-time-unit clock.
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    data_mem_responder #(.DEPTH(1024), .WAIT_STATES(WS)) u_dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .busy      (busy[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  function automatic void model_store(input int d, input logic [31:0] addr, input logic [31:0] data);
    if (addr < 32'd1024) begin
      model_mem[d][addr[9:0]]     = data;
      model_written[d][addr[9:0]] = 1'b1;
    end
  endfunction

  // Drives one transaction from a negedge, holds off rsp_ready for 'hold'
  // cycles, and reports data, error, edges-to-valid and hold stability.
  task automatic run_txn(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, output logic [31:0] rdata, output logic err,
                         output int lat, output bit stable);
    int n;
    stable = 1'b1;
    rdata  = 32'd0;
    err    = 1'b0;
    @(negedge clock);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    rsp_ready[d] = 1'b0;
    @(negedge clock);
    req_valid[d] = 1'b0;
    n = 1;
    while (rsp_valid[d] !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (rsp_valid[d] !== 1'b1) begin
      lat = -1;
      return;
    end
    lat   = n;
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rdata || rsp_err[d] !== err) stable = 1'b0;
    end
    rsp_ready[d] = 1'b1;
    @(negedge clock);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      tests_run++; if (req_ready[d] !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_ready[%0d]: got %b expected 1", d, req_ready[d]); end
      tests_run++; if (rsp_valid[d] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid[%0d]: got %b expected 0", d, rsp_valid[d]); end
      tests_run++; if (rsp_rdata[d] !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_rsp_rdata[%0d]: got %h expected 0", d, rsp_rdata[d]); end
      tests_run++; if (rsp_err[d] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_err[%0d]: got %b expected 0", d, rsp_err[d]); end
      tests_run++; if (busy[d] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy[%0d]: got %b expected 0", d, busy[d]); end
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; bit st;
    run_txn(0, 1'b1, 32'd120, 32'd85, 0, rd, er, lat, st);
    model_store(0, 32'd120, 32'd85);
    tests_run++; if (lat !== 1) begin tests_failed++; $display("[TB] FAIL store120_latency: got %0d expected 1", lat); end
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("[TB] FAIL store120_err: got %b expected 0", er); end
    tests_run++; if (rd !== 32'd0) begin tests_failed++; $display("[TB] FAIL store120_rdata: got %h expected 0", rd); end
    tests_run++; if (req_ready[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL store120_back_to_idle: got %b expected 1", req_ready[0]); end
    run_txn(0, 1'b0, 32'd120, 32'd0, 0, rd, er, lat, st);
    tests_run++; if (rd !== 32'd85) begin tests_failed++; $display("[TB] FAIL load120_rdata: got %0d expected 85", rd); end
    tests_run++; if (lat !== 1) begin tests_failed++; $display("[TB] FAIL load120_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_program_flow();
    logic [31:0] rd; logic er; int lat; bit st; logic [31:0] sum;
    run_txn(0, 1'b1, 32'd120, 32'd85, 0, rd, er, lat, st);
    model_store(0, 32'd120, 32'd85);
    run_txn(0, 1'b0, 32'd120, 32'd0, 0, rd, er, lat, st);
    tests_run++; if (rd !== 32'd85) begin tests_failed++; $display("[TB] FAIL flow_load120: got %0d expected 85", rd); end
    sum = rd + 32'd45;
    run_txn(0, 1'b1, 32'd121, sum, 0, rd, er, lat, st);
    model_store(0, 32'd121, 32'd130);
    run_txn(0, 1'b0, 32'd121, 32'd0, 0, rd, er, lat, st);
    tests_run++; if (rd !== 32'd130) begin tests_failed++; $display("[TB] FAIL flow_load121: got %0d expected 130", rd); end
    run_txn(0, 1'b0, 32'd120, 32'd0, 0, rd, er, lat, st);
    tests_run++; if (rd !== 32'd85) begin tests_failed++; $display("[TB] FAIL flow_reload120: got %0d expected 85", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int lat; bit st; int n; int bad_ready;
    run_txn(1, 1'b1, 32'd8, 32'hCAFE_0008, 0, rd, er, lat, st);
    model_store(1, 32'd8, 32'hCAFE_0008);
    tests_run++; if (lat !== 4) begin tests_failed++; $display("[TB] FAIL ws3_latency: got %0d expected 4", lat); end
    @(negedge clock);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'd7; req_wdata[1] = 32'hA5A5_0007;
    rsp_ready[1] = 1'b1;
    @(negedge clock);
    req_addr[1] = 32'd8; req_wdata[1] = 32'hBBBB_BBBB;
    model_store(1, 32'd7, 32'hA5A5_0007);
    tests_run++; if (busy[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL ws3_busy_in_wait: got %b expected 1", busy[1]); end
    n = 1; bad_ready = 0;
    while (rsp_valid[1] !== 1'b1 && n < 64) begin
      if (req_ready[1] !== 1'b0) bad_ready++;
      @(negedge clock);
      n++;
    end
    if (req_ready[1] !== 1'b0) bad_ready++;
    tests_run++; if (n !== 4) begin tests_failed++; $display("[TB] FAIL ws3_held_latency: got %0d expected 4", n); end
    tests_run++; if (bad_ready !== 0) begin tests_failed++; $display("[TB] FAIL ws3_ready_low: got %0d high cycles expected 0", bad_ready); end
    req_valid[1] = 1'b0;
    @(negedge clock);
    rsp_ready[1] = 1'b0;
    tests_run++; if (req_ready[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL ws3_idle_ready: got %b expected 1", req_ready[1]); end
    tests_run++; if (busy[1] !== 1'b0) begin tests_failed++; $display("[TB] FAIL ws3_idle_busy: got %b expected 0", busy[1]); end
    run_txn(1, 1'b0, 32'd8, 32'd0, 0, rd, er, lat, st);
    tests_run++; if (rd !== 32'hCAFE_0008) begin tests_failed++; $display("[TB] FAIL ws3_ignored_req: got %h expected cafe0008", rd); end
    run_txn(1, 1'b0, 32'd7, 32'd0, 0, rd, er, lat, st);
    tests_run++; if (rd !== 32'hA5A5_0007) begin tests_failed++; $display("[TB] FAIL ws3_load7: got %h expected a5a50007", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; bit st;
    run_txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 0, rd, er, lat, st);
    model_store(0, 32'd5, 32'hDEAD_BEEF);
    run_txn(0, 1'b0, 32'd5, 32'd0, 3, rd, er, lat, st);
    tests_run++; if (rd !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL bp_rdata: got %h expected deadbeef", rd); end
    tests_run++; if (st !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_stable: got %b expected 1", st); end
    tests_run++; if (rsp_valid[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_valid_dropped: got %b expected 0", rsp_valid[0]); end
    tests_run++; if (req_ready[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_idle: got %b expected 1", req_ready[0]); end
    tests_run++; if (rsp_rdata[0] !== 32'd0) begin tests_failed++; $display("[TB] FAIL bp_rdata_cleared: got %h expected 0", rsp_rdata[0]); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat; bit st;
    run_txn(0, 1'b1, 32'd0, 32'h0BAD_F00D, 0, rd, er, lat, st);
    model_store(0, 32'd0, 32'h0BAD_F00D);
    run_txn(0, 1'b1, 32'd1024, 32'd7, 0, rd, er, lat, st);
    tests_run++; if (er !== 1'b1) begin tests_failed++; $display("[TB] FAIL oor_store_err: got %b expected 1", er); end
    tests_run++; if (rd !== 32'd0) begin tests_failed++; $display("[TB] FAIL oor_store_rdata: got %h expected 0", rd); end
    tests_run++; if (lat !== 1) begin tests_failed++; $display("[TB] FAIL oor_store_latency: got %0d expected 1", lat); end
    run_txn(0, 1'b0, 32'd0, 32'd0, 0, rd, er, lat, st);
    tests_run++; if (rd !== 32'h0BAD_F00D) begin tests_failed++; $display("[TB] FAIL oor_alias_untouched: got %h expected 0badf00d", rd); end
    run_txn(0, 1'b0, 32'hFFFF_FFFF, 32'd0, 0, rd, er, lat, st);
    tests_run++; if (er !== 1'b1) begin tests_failed++; $display("[TB] FAIL oor_load_err: got %b expected 1", er); end
    tests_run++; if (rd !== 32'd0) begin tests_failed++; $display("[TB] FAIL oor_load_rdata: got %h expected 0", rd); end
    run_txn(0, 1'b1, 32'd1023, 32'h0000_1234, 0, rd, er, lat, st);
    model_store(0, 32'd1023, 32'h0000_1234);
    run_txn(0, 1'b0, 32'd1023, 32'd0, 0, rd, er, lat, st);
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("[TB] FAIL top_addr_err: got %b expected 0", er); end
    tests_run++; if (rd !== 32'h0000_1234) begin tests_failed++; $display("[TB] FAIL top_addr_rdata: got %h expected 00001234", rd); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd; logic er; int lat; bit st; int n;
    run_txn(2, 1'b1, 32'd10, 32'h0000_0055, 0, rd, er, lat, st);
    model_store(2, 32'd10, 32'h0000_0055);
    tests_run++; if (lat !== 3) begin tests_failed++; $display("[TB] FAIL ws2_latency: got %0d expected 3", lat); end
    @(negedge clock);
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'd10; req_wdata[2] = 32'd99;
    @(negedge clock);
    req_valid[2] = 1'b0;
    tests_run++; if (busy[2] !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_wait_busy_before: got %b expected 1", busy[2]); end
    #1 reset_n = 1'b0;
    #1;
    tests_run++; if (req_ready[2] !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_wait_ready: got %b expected 1", req_ready[2]); end
    tests_run++; if (busy[2] !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_wait_busy: got %b expected 0", busy[2]); end
    tests_run++; if (rsp_valid[2] !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_wait_valid: got %b expected 0", rsp_valid[2]); end
    reset_n = 1'b1;
    run_txn(2, 1'b0, 32'd10, 32'd0, 0, rd, er, lat, st);
    tests_run++; if (rd !== 32'h0000_0055) begin tests_failed++; $display("[TB] FAIL rst_wait_store_dropped: got %h expected 00000055", rd); end
    @(negedge clock);
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'd11; req_wdata[2] = 32'h0000_0077;
    rsp_ready[2] = 1'b0;
    @(negedge clock);
    req_valid[2] = 1'b0;
    n = 1;
    while (rsp_valid[2] !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    tests_run++; if (rsp_valid[2] !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_resp_reached: got %b expected 1", rsp_valid[2]); end
    #1 reset_n = 1'b0;
    #1;
    tests_run++; if (rsp_valid[2] !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_resp_valid: got %b expected 0", rsp_valid[2]); end
    tests_run++; if (rsp_err[2] !== 1'b0 || rsp_rdata[2] !== 32'd0) begin tests_failed++; $display("[TB] FAIL rst_resp_outputs: got err %b rdata %h expected 0 0", rsp_err[2], rsp_rdata[2]); end
    reset_n = 1'b1;
    model_store(2, 32'd11, 32'h0000_0077);
    run_txn(2, 1'b0, 32'd11, 32'd0, 0, rd, er, lat, st);
    tests_run++; if (rd !== 32'h0000_0077) begin tests_failed++; $display("[TB] FAIL rst_resp_store_kept: got %h expected 00000077", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int lat; bit st;
    logic [31:0] addr; logic [31:0] wdata; bit wr; int hold; int pick;
    logic [31:0] exp_rd; logic exp_er;
    for (int d = 0; d < 3; d++) begin
      for (int t = 0; t < 25; t++) begin
        pick  = int'($urandom_range(0, 9));
        wdata = $urandom;
        hold  = int'($urandom_range(0, 2));
        if (pick == 0) begin
          addr = ($urandom_range(0, 1) == 1) ? (32'd1024 + $urandom_range(0, 200)) : (32'hFFFF_0000 | $urandom_range(0, 65535));
          wr   = ($urandom_range(0, 1) == 1);
        end else begin
          addr = ($urandom_range(0, 3) == 0) ? (32'd1008 + $urandom_range(0, 15)) : $urandom_range(0, 15);
          wr   = !model_written[d][addr[9:0]] || ($urandom_range(0, 1) == 1);
        end
        if (addr >= 32'd1024) begin
          exp_rd = 32'd0; exp_er = 1'b1;
        end else if (wr) begin
          exp_rd = 32'd0; exp_er = 1'b0;
        end else begin
          exp_rd = model_mem[d][addr[9:0]]; exp_er = 1'b0;
        end
        run_txn(d, wr, addr, wdata, hold, rd, er, lat, st);
        if (wr) model_store(d, addr, wdata);
        tests_run++; if (lat !== ws_of(d) + 1) begin tests_failed++; $display("[TB] FAIL rand_latency[%0d.%0d]: got %0d expected %0d", d, t, lat, ws_of(d) + 1); end
        tests_run++; if (er !== exp_er) begin tests_failed++; $display("[TB] FAIL rand_err[%0d.%0d] addr %h: got %b expected %b", d, t, addr, er, exp_er); end
        tests_run++; if (rd !== exp_rd) begin tests_failed++; $display("[TB] FAIL rand_rdata[%0d.%0d] addr %h: got %h expected %h", d, t, addr, rd, exp_rd); end
        tests_run++; if (st !== 1'b1) begin tests_failed++; $display("[TB] FAIL rand_stable[%0d.%0d]: got %b expected 1", d, t, st); end
      end
    end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 1024; a++) begin
        model_mem[d][a]     = 32'd0;
        model_written[d][a] = 1'b0;
      end
    end
    test_reset();
    test_store_load();
    test_program_flow();
    test_wait_states();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
